gamepad_pmod_tx: RTL and testbench
==================================

GAMEPAD_PMOD_TX -- requirements
Module: gamepad_pmod_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 32: game_clk half-period in clk cycles, legal range 2..255.
REQ-002 SHALL have parameter FRAME_CYCLES, default 1066667: auto-frame period in clk cycles (60 Hz at 64 MHz), 21-bit counter.
REQ-003 SHALL have port clk, input, 1: single system clock; all logic rising-edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port auto_en, input, 1: enables periodic frame generation.
REQ-006 SHALL have port start, input, 1: one-cycle request for an immediate frame.
REQ-007 SHALL have port buttons_a, input, 12: controller A state, 1 = pressed, bit 11 = B … bit 0 = R (SNES order).
REQ-008 SHALL have port buttons_b, input, 12: controller B state, same encoding.
REQ-009 SHALL have port present_a and present_b, input, 1 each: controller attached.
REQ-010 SHALL have port game_latch, output, 1: latch strobe to receiver.
REQ-011 SHALL have port game_clk, output, 1: shift clock; receiver samples game_data on its rising edge.
REQ-012 SHALL have port game_data, output, 1: serial button data.
REQ-013 SHALL have ports busy (output, 1: frame in progress) and frame_done (output, 1: one-cycle pulse at end of frame).

Function
REQ-014 SHALL use FSM states IDLE, SHIFT_LO, SHIFT_HI, LATCH.
REQ-015 IDLE -> SHIFT_LO when start=1, or when auto_en=1 and the frame counter reaches FRAME_CYCLES-1; the counter then reloads to 0.
REQ-016 Frame counter SHALL count only while auto_en=1 and SHALL clear when auto_en=0; it keeps counting during a frame, and an expiry inside a frame is held pending and launches the next frame on return to IDLE.
REQ-017 On leaving IDLE SHALL snapshot a 24-bit shift word {A', B'}, where X' = buttons_x if present_x=1, else 12'hFFF; later input changes SHALL NOT affect the frame.
REQ-018 Bits SHALL be sent MSB first (word bit 23 first, bit 0 last), 24 bits per frame.
REQ-019 SHIFT_LO: game_clk=0 for CLK_DIV cycles, with game_data driven to the current bit on the first cycle; then SHIFT_HI: game_clk=1 for CLK_DIV cycles, with game_data stable.
REQ-020 After the SHIFT_HI of bit 0 SHALL enter LATCH: game_clk=0, game_latch=1 for CLK_DIV cycles, then IDLE with game_latch=0.
REQ-021 frame_done SHALL pulse for exactly one cycle on the LATCH->IDLE transition.
REQ-022 busy SHALL be 1 in every state except IDLE.
REQ-023 A frame SHALL last exactly (48+1)*CLK_DIV cycles from IDLE exit to IDLE entry.
REQ-024 start while busy SHALL be ignored and SHALL NOT queue.
REQ-025 start and auto-expiry in the same IDLE cycle SHALL launch a single frame.
REQ-026 In IDLE, game_clk=0, game_latch=0, and game_data holds the last bit sent.
REQ-027 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-028 rst_n=0 SHALL asynchronously force: state IDLE, game_latch=0, game_clk=0, game_data=0, busy=0, frame_done=0, frame counter=0, pending flag=0, shift word=0.
REQ-029 Reset mid-frame SHALL abort immediately with no latch pulse; after release, the next frame SHALL start from bit 23.

Structure
REQ-030 A shared package SHALL hold the FSM state enum, GP_BITS=24, GP_BTN_PER_PAD=12, and the absent-pad value 12'hFFF, for reuse by the tinyQV game receiver and its bench.
REQ-031 SHALL be a single module with no sub-modules; the half-period counter (8 bit), bit index (5 bit) and frame counter (21 bit) SHALL be local.

Verification
REQ-032 CLK_DIV=2, auto_en=0, present_a=present_b=1, A=12'hA5C, B=12'h3F1, start pulse -> 24 game_clk rises, captured word 24'hA5C3F1, latch high 2 cycles, frame_done once, 98 cycles busy.
REQ-033 present_b=0, B=12'h000, start -> captured low 12 bits = 12'hFFF.
REQ-034 CLK_DIV=2, FRAME_CYCLES=200, auto_en=1 -> frame starts every 200 cycles; frame_done spacing 200 cycles over 5 frames.
REQ-035 start repeated every cycle during a frame, and buttons_a changed mid-frame -> exactly one frame, carrying the snapshot value.
REQ-036 rst_n asserted after bit 10 -> all outputs 0 in the same cycle, no latch; after release, start -> full correct 24-bit frame.
REQ-037 Bench monitor SHALL check that game_data never changes while game_clk=1 and that game_latch and game_clk are never high together.

Source files
------------

// File: rtl/gamepad_pmod_tx_pkg.sv
// Shared definitions for the SNES-style gamepad PMOD link: frame geometry,
// FSM states and the word-assembly helper used by transmitter and receiver.
package gamepad_pmod_tx_pkg;

    localparam int unsigned GP_BITS        = 24;
    localparam int unsigned GP_BTN_PER_PAD = 12;

    // A missing controller reads as all buttons pressed (open-collector idle).
    localparam logic [GP_BTN_PER_PAD-1:0] GP_ABSENT_PAD = 12'hFFF;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StShiftLo = 2'd1,
        StShiftHi = 2'd2,
        StLatch   = 2'd3
    } gp_state_e;

    function automatic logic [GP_BITS-1:0] gp_frame_word(
        input logic [GP_BTN_PER_PAD-1:0] buttons_a,
        input logic                      present_a,
        input logic [GP_BTN_PER_PAD-1:0] buttons_b,
        input logic                      present_b
    );
        logic [GP_BTN_PER_PAD-1:0] pad_a;
        logic [GP_BTN_PER_PAD-1:0] pad_b;
        pad_a = present_a ? buttons_a : GP_ABSENT_PAD;
        pad_b = present_b ? buttons_b : GP_ABSENT_PAD;
        return {pad_a, pad_b};
    endfunction

endpackage

// File: rtl/gamepad_pmod_tx.sv
// Serialises two 12-button controller states into a 24-bit clocked frame
// followed by a latch strobe, on request or at a fixed frame rate.
module gamepad_pmod_tx
    import gamepad_pmod_tx_pkg::*;
#(
    parameter int unsigned CLK_DIV      = 32,
    parameter int unsigned FRAME_CYCLES = 1066667
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      auto_en,
    input  logic                      start,
    input  logic [GP_BTN_PER_PAD-1:0] buttons_a,
    input  logic [GP_BTN_PER_PAD-1:0] buttons_b,
    input  logic                      present_a,
    input  logic                      present_b,
    output logic                      game_latch,
    output logic                      game_clk,
    output logic                      game_data,
    output logic                      busy,
    output logic                      frame_done
);

    localparam logic [7:0]  DivLast   = 8'(CLK_DIV - 1);
    localparam logic [20:0] FrameLast = 21'(FRAME_CYCLES - 1);
    localparam logic [4:0]  BitFirst  = 5'(GP_BITS - 1);

    gp_state_e            state_q, state_d;
    logic [7:0]           div_q, div_d;
    logic [4:0]           bit_q, bit_d;
    logic [20:0]          cnt_q, cnt_d;
    logic                 pend_q, pend_d;
    logic [GP_BITS-1:0]   shift_q, shift_d;
    logic                 latch_q, latch_d;
    logic                 gclk_q, gclk_d;
    logic                 data_q, data_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic                 expire;
    logic                 div_last;
    logic [GP_BITS-1:0]   snap_word;

    assign expire    = auto_en && (cnt_q == FrameLast);
    assign div_last  = (div_q == DivLast);
    assign snap_word = gp_frame_word(buttons_a, present_a, buttons_b, present_b);

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        pend_d  = pend_q;
        done_d  = 1'b0;

        if (!auto_en || expire) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 21'd1;
        end

        unique case (state_q)
            StIdle: begin
                if (start || expire || pend_q) begin
                    state_d = StShiftLo;
                    shift_d = snap_word;
                    data_d  = snap_word[GP_BITS-1];
                    bit_d   = BitFirst;
                    div_d   = '0;
                    pend_d  = 1'b0;
                end
            end
            StShiftLo: begin
                if (div_last) begin
                    state_d = StShiftHi;
                    div_d   = '0;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            StShiftHi: begin
                if (div_last) begin
                    div_d = '0;
                    if (bit_q == 5'd0) begin
                        state_d = StLatch;
                    end else begin
                        // Next bit goes out on the first cycle of the low phase.
                        state_d = StShiftLo;
                        bit_d   = bit_q - 5'd1;
                        shift_d = {shift_q[GP_BITS-2:0], 1'b0};
                        data_d  = shift_q[GP_BITS-2];
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            StLatch: begin
                if (div_last) begin
                    state_d = StIdle;
                    div_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Expiry mid-frame is remembered and fires on return to idle.
        if (expire && (state_q != StIdle)) begin
            pend_d = 1'b1;
        end

        busy_d  = (state_d != StIdle);
        gclk_d  = (state_d == StShiftHi);
        latch_d = (state_d == StLatch);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            div_q   <= '0;
            bit_q   <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            shift_q <= '0;
            latch_q <= 1'b0;
            gclk_q  <= 1'b0;
            data_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            shift_q <= shift_d;
            latch_q <= latch_d;
            gclk_q  <= gclk_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign game_latch = latch_q;
    assign game_clk   = gclk_q;
    assign game_data  = data_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_gamepad_pmod_tx.sv
// Directed bench for gamepad_pmod_tx: a receiver model on game_clk rises and
// protocol monitors, with hand-computed expected frames and timings.
module tb_gamepad_pmod_tx;

    logic        clk;
    logic        rst_n;
    logic        auto_en;
    logic        start;
    logic [11:0] buttons_a;
    logic [11:0] buttons_b;
    logic        present_a;
    logic        present_b;
    logic        game_latch;
    logic        game_clk;
    logic        game_data;
    logic        busy;
    logic        frame_done;

    int unsigned n_cmp;
    int unsigned n_bad;

    gamepad_pmod_tx #(
        .CLK_DIV      (2),
        .FRAME_CYCLES (200)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .auto_en    (auto_en),
        .start      (start),
        .buttons_a  (buttons_a),
        .buttons_b  (buttons_b),
        .present_a  (present_a),
        .present_b  (present_b),
        .game_latch (game_latch),
        .game_clk   (game_clk),
        .game_data  (game_data),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: monotonic totals only, sampled on the falling edge.
    int unsigned cycle;
    int unsigned rises;
    int unsigned latch_cyc;
    int unsigned done_tot;
    int unsigned busy_cyc;
    int unsigned viol;
    logic [23:0] rx_word;
    logic        clk_prev;
    logic        data_prev;
    int unsigned done_stamp[$];

    initial begin
        cycle = 0; rises = 0; latch_cyc = 0; done_tot = 0; busy_cyc = 0; viol = 0;
        rx_word = '0; clk_prev = 1'b0; data_prev = 1'b0;
    end

    always @(negedge clk) begin
        cycle = cycle + 1;
        if (game_clk && !clk_prev) begin
            rises   = rises + 1;
            rx_word = {rx_word[22:0], game_data};
        end
        if (game_clk && clk_prev && (game_data != data_prev)) viol = viol + 1;
        if (game_clk && game_latch) viol = viol + 1;
        if (game_latch) latch_cyc = latch_cyc + 1;
        if (busy) busy_cyc = busy_cyc + 1;
        if (frame_done) begin
            done_tot = done_tot + 1;
            done_stamp.push_back(cycle);
        end
        clk_prev  = game_clk;
        data_prev = game_data;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int unsigned base, input int unsigned budget,
                             output logic timed_out);
        int unsigned n;
        n = 0;
        while (done_tot <= base && n < budget) begin
            @(negedge clk);
            n = n + 1;
        end
        timed_out = (done_tot <= base);
    endtask

    int unsigned b_rise, b_latch, b_done, b_busy;
    logic        to;

    task automatic snap_base();
        b_rise  = rises;
        b_latch = latch_cyc;
        b_done  = done_tot;
        b_busy  = busy_cyc;
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        rst_n = 1'b0; auto_en = 1'b0; start = 1'b0;
        buttons_a = '0; buttons_b = '0; present_a = 1'b1; present_b = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_outputs", {27'd0, game_latch, game_clk, game_data, busy, frame_done}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic frame: word A5C3F1, 24 rises, 2-cycle latch, 98 busy cycles.
        buttons_a = 12'hA5C; buttons_b = 12'h3F1;
        snap_base();
        pulse_start();
        wait_done(b_done, 300, to);
        check_eq("f1_timeout", {31'd0, to}, 32'd0);
        repeat (5) @(negedge clk);
        check_eq("f1_rises", rises - b_rise, 32'd24);
        check_eq("f1_word", {8'd0, rx_word}, 32'h00A5C3F1);
        check_eq("f1_latch", latch_cyc - b_latch, 32'd2);
        check_eq("f1_done", done_tot - b_done, 32'd1);
        check_eq("f1_busy", busy_cyc - b_busy, 32'd98);
        check_eq("f1_idle_out", {29'd0, game_data, game_clk, game_latch}, 32'h4);

        // Absent pad B reads as all pressed.
        present_b = 1'b0; buttons_b = 12'h000;
        snap_base();
        pulse_start();
        wait_done(b_done, 300, to);
        check_eq("f2_timeout", {31'd0, to}, 32'd0);
        repeat (3) @(negedge clk);
        check_eq("f2_word", {8'd0, rx_word}, 32'h00A5CFFF);
        present_b = 1'b1;

        // Start held during a frame and inputs changed mid-frame: one frame, snapshot data.
        buttons_a = 12'h123; buttons_b = 12'h456;
        snap_base();
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (i == 40) buttons_a = 12'hFFF;
        end
        start = 1'b0;
        wait_done(b_done, 300, to);
        check_eq("f3_timeout", {31'd0, to}, 32'd0);
        repeat (20) @(negedge clk);
        check_eq("f3_done", done_tot - b_done, 32'd1);
        check_eq("f3_rises", rises - b_rise, 32'd24);
        check_eq("f3_word", {8'd0, rx_word}, 32'h00123456);

        // Reset after bit 10 has been sent (14 rises), then a full clean frame.
        buttons_a = 12'h5A5; buttons_b = 12'hC3C;
        snap_base();
        pulse_start();
        for (int i = 0; i < 300 && (rises - b_rise) < 14; i++) @(negedge clk);
        check_eq("f4_reached", rises - b_rise, 32'd14);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_eq("f4_rst_out", {27'd0, game_latch, game_clk, game_data, busy, frame_done}, 32'd0);
        repeat (3) @(negedge clk);
        check_eq("f4_no_latch", latch_cyc - b_latch, 32'd0);
        check_eq("f4_no_done", done_tot - b_done, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        snap_base();
        pulse_start();
        wait_done(b_done, 300, to);
        check_eq("f4_timeout", {31'd0, to}, 32'd0);
        repeat (3) @(negedge clk);
        check_eq("f4_rises", rises - b_rise, 32'd24);
        check_eq("f4_word", {8'd0, rx_word}, 32'h005A5C3C);

        // Auto frames: 200-cycle spacing over 5 frames.
        buttons_a = 12'h0F0; buttons_b = 12'h00F;
        snap_base();
        done_stamp.delete();
        @(negedge clk);
        auto_en = 1'b1;
        wait_done(b_done + 4, 1400, to);
        check_eq("auto_timeout", {31'd0, to}, 32'd0);
        auto_en = 1'b0;
        check_eq("auto_count", done_stamp.size(), 32'd5);
        if (done_stamp.size() >= 5) begin
            for (int i = 1; i < 5; i++) begin
                check_eq($sformatf("auto_gap%0d", i), done_stamp[i] - done_stamp[i-1], 32'd200);
            end
        end
        repeat (3) @(negedge clk);
        check_eq("auto_word", {8'd0, rx_word}, 32'h000F000F);

        check_eq("monitor_viol", viol, 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
